// File: rtl/md_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op codes, FSM states, latency.
package md_pkg;

    localparam int MD_WIDTH  = 32;
    localparam int MD_CYCLES = MD_WIDTH + 2;

    typedef enum logic [1:0] {
        MD_MUL  = 2'b00,
        MD_DIV  = 2'b01,
        MD_MTHI = 2'b10,
        MD_MTLO = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10
    } md_state_e;

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/result bundle between the EX stage issue logic and the multiply/divide unit.
interface mul_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic             sign;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, sign, a, b, flush,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, sign, a, b, flush,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/md_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
// acc layout: multiply {partial product high, remaining multiplier bits};
//             divide   {partial remainder, dividend bits / quotient bits}.
module md_step #(
    parameter int WIDTH = 32
) (
    input  logic               is_div_i,
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   operand_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic [WIDTH:0] sum_s;
    logic [WIDTH:0] rem_sh_s;
    logic [WIDTH:0] diff_s;

    // Compute both candidate steps and select the one for the active op.
    always_comb begin
        sum_s    = {1'b0, acc_i[2*WIDTH-1:WIDTH]}
                 + (acc_i[0] ? {1'b0, operand_i} : {(WIDTH+1){1'b0}});
        rem_sh_s = acc_i[2*WIDTH-1:WIDTH-1];
        diff_s   = rem_sh_s - {1'b0, operand_i};
        if (is_div_i) begin
            // A borrow out of the subtraction means the divisor did not fit: restore.
            if (diff_s[WIDTH]) begin
                acc_o = {rem_sh_s[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
            end else begin
                acc_o = {diff_s[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
            end
        end else begin
            // Carry of the add becomes the top bit after the right shift.
            acc_o = {sum_s, acc_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative HI/LO multiply/divide unit. Works on operand magnitudes for WIDTH
// cycles, then applies sign correction and writes HI/LO in a final fix cycle.
module mul_div_unit
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    mul_div_unit_if.slave  md
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};

    md_op_e             op_s;
    logic               a_neg_s;
    logic               b_neg_s;
    logic               b_zero_s;
    logic [WIDTH-1:0]   mag_a_s;
    logic [WIDTH-1:0]   mag_b_s;
    logic [WIDTH-1:0]   dvd_s;
    logic [2*WIDTH-1:0] step_acc_s;
    logic [2*WIDTH-1:0] prod_fix_s;
    logic [WIDTH-1:0]   quot_fix_s;
    logic [WIDTH-1:0]   rem_fix_s;

    md_state_e          state_q;
    logic [CNT_W-1:0]   counter_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   operand_q;
    logic               is_div_q;
    logic               neg_quo_q;
    logic               neg_rem_q;
    logic               dbz_q;
    logic               busy_q;
    logic               done_q;
    logic               dbz_out_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    // Operand magnitudes and sign info from the live request, consumed at the start edge.
    always_comb begin
        op_s     = md_op_e'(md.op);
        a_neg_s  = md.sign & md.a[WIDTH-1];
        b_neg_s  = md.sign & md.b[WIDTH-1];
        mag_a_s  = a_neg_s ? (~md.a + ONE_W) : md.a;
        mag_b_s  = b_neg_s ? (~md.b + ONE_W) : md.b;
        b_zero_s = (md.b == {WIDTH{1'b0}});
        // Divide by zero keeps the raw dividend so it falls out unchanged as the remainder.
        if ((op_s == MD_DIV) && b_zero_s) begin
            dvd_s = md.a;
        end else begin
            dvd_s = mag_a_s;
        end
    end

    md_step #(.WIDTH(WIDTH)) u_step (
        .is_div_i  (is_div_q),
        .acc_i     (acc_q),
        .operand_i (operand_q),
        .acc_o     (step_acc_s)
    );

    // Sign correction of the finished magnitude result.
    always_comb begin
        prod_fix_s = neg_quo_q ? (~acc_q + ONE_2W) : acc_q;
        quot_fix_s = neg_quo_q ? (~acc_q[WIDTH-1:0] + ONE_W) : acc_q[WIDTH-1:0];
        rem_fix_s  = neg_rem_q ? (~acc_q[2*WIDTH-1:WIDTH] + ONE_W) : acc_q[2*WIDTH-1:WIDTH];
    end

    // Control FSM, datapath registers and registered HI/LO/status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            counter_q <= {CNT_W{1'b0}};
            acc_q     <= {(2*WIDTH){1'b0}};
            operand_q <= {WIDTH{1'b0}};
            is_div_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dbz_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_out_q <= 1'b0;
            hi_q      <= {WIDTH{1'b0}};
            lo_q      <= {WIDTH{1'b0}};
        end else begin
            done_q    <= 1'b0;
            dbz_out_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // A simultaneous flush drops the request entirely.
                    if (md.start && !md.flush) begin
                        case (op_s)
                            MD_MUL: begin
                                acc_q     <= {{WIDTH{1'b0}}, mag_b_s};
                                operand_q <= mag_a_s;
                                is_div_q  <= 1'b0;
                                neg_quo_q <= a_neg_s ^ b_neg_s;
                                neg_rem_q <= 1'b0;
                                dbz_q     <= 1'b0;
                                counter_q <= {CNT_W{1'b0}};
                                busy_q    <= 1'b1;
                                state_q   <= S_CALC;
                            end
                            MD_DIV: begin
                                acc_q     <= {{WIDTH{1'b0}}, dvd_s};
                                operand_q <= mag_b_s;
                                is_div_q  <= 1'b1;
                                neg_quo_q <= (a_neg_s ^ b_neg_s) & ~b_zero_s;
                                neg_rem_q <= a_neg_s & ~b_zero_s;
                                dbz_q     <= b_zero_s;
                                counter_q <= {CNT_W{1'b0}};
                                busy_q    <= 1'b1;
                                state_q   <= S_CALC;
                            end
                            MD_MTHI: hi_q <= md.a;
                            MD_MTLO: lo_q <= md.a;
                            default: state_q <= S_IDLE;
                        endcase
                    end
                end
                S_CALC: begin
                    if (md.flush) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        acc_q     <= step_acc_s;
                        counter_q <= counter_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        if (counter_q == CNT_W'(WIDTH - 1)) begin
                            state_q <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                    if (!md.flush) begin
                        if (is_div_q) begin
                            hi_q <= rem_fix_s;
                            lo_q <= quot_fix_s;
                        end else begin
                            hi_q <= prod_fix_s[2*WIDTH-1:WIDTH];
                            lo_q <= prod_fix_s[WIDTH-1:0];
                        end
                        done_q    <= 1'b1;
                        dbz_out_q <= dbz_q;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign md.busy        = busy_q;
    assign md.done        = done_q;
    assign md.div_by_zero = dbz_out_q;
    assign md.hi          = hi_q;
    assign md.lo          = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: an arithmetic/timeline model checked every
// cycle, plus hand-computed literal expectations for each directed vector.
module tb_mul_div_unit;

    localparam int W = 32;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    mul_div_unit_if #(.WIDTH(W)) bus ();

    mul_div_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .md    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Result of a MUL/DIV from plain arithmetic: {div_by_zero, hi, lo}.
    function automatic logic [64:0] md_model(input logic [1:0] op, input logic sgn,
                                             input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] q;
        logic signed [63:0] r;
        logic [63:0]        up;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        if (op == 2'b00) begin
            if (sgn) up = sa * sb;
            else     up = {32'h0, a} * {32'h0, b};
            return {1'b0, up};
        end
        if (b == 32'h0) return {1'b1, a, 32'hFFFF_FFFF};
        if (sgn) begin
            q = sa / sb;
            r = sa % sb;
            return {1'b0, r[31:0], q[31:0]};
        end
        return {1'b0, a % b, a / b};
    endfunction

    logic [64:0] model_res;
    assign model_res = md_model(bus.op, bus.sign, bus.a, bus.b);

    // Timeline model: an accepted MUL/DIV delivers its result 34 cycles after its start cycle.
    int          m_left;
    logic [64:0] m_pend;
    logic        exp_busy, exp_done, exp_dbz;
    logic [31:0] exp_hi, exp_lo;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0; m_pend <= 65'h0;
            exp_busy <= 1'b0; exp_done <= 1'b0; exp_dbz <= 1'b0;
            exp_hi <= 32'h0; exp_lo <= 32'h0;
        end else begin
            exp_done <= 1'b0;
            exp_dbz  <= 1'b0;
            if (m_left == 0) begin
                if (bus.start && !bus.flush) begin
                    if (bus.op[1] == 1'b0) begin
                        m_pend   <= model_res;
                        m_left   <= 33;
                        exp_busy <= 1'b1;
                    end else if (bus.op == 2'b10) exp_hi <= bus.a;
                    else exp_lo <= bus.a;
                end
            end else if (bus.flush) begin
                m_left   <= 0;
                exp_busy <= 1'b0;
            end else if (m_left == 1) begin
                {exp_dbz, exp_hi, exp_lo} <= m_pend;
                exp_done <= 1'b1;
                exp_busy <= 1'b0;
                m_left   <= 0;
            end else begin
                m_left <= m_left - 1;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            n_vec++;
            if ({bus.busy, bus.done, bus.div_by_zero, bus.hi, bus.lo} !==
                {exp_busy, exp_done, exp_dbz, exp_hi, exp_lo}) begin
                n_err++;
                $display("FAIL cycle@%0t: got busy=%b done=%b dbz=%b hi=%h lo=%h, expected busy=%b done=%b dbz=%b hi=%h lo=%h",
                         $time, bus.busy, bus.done, bus.div_by_zero, bus.hi, bus.lo,
                         exp_busy, exp_done, exp_dbz, exp_hi, exp_lo);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Caller is just after a rising edge; start is sampled at the next edge, then operands scrambled.
    task automatic issue(input logic [1:0] op, input logic sgn, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1; bus.op = op; bus.sign = sgn; bus.a = a; bus.b = b;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.a = 32'hDEAD_BEEF; bus.b = 32'h0BAD_F00D;
    endtask

    task automatic wait_done(output int n);
        n = 1;
        while (bus.done !== 1'b1 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        if (bus.done !== 1'b1) begin
            n_vec++; n_err++;
            $display("FAIL done_timeout: got no done after %0d cycles, expected done at 34", n);
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic sgn,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input logic edbz);
        int n;
        issue(op, sgn, a, b);
        wait_done(n);
        chk({name, "_latency"}, 64'(n), 64'd34);
        chk({name, "_hi"}, {32'h0, bus.hi}, {32'h0, ehi});
        chk({name, "_lo"}, {32'h0, bus.lo}, {32'h0, elo});
        chk({name, "_dbz"}, {63'h0, bus.div_by_zero}, {63'h0, edbz});
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.op = 2'b00; bus.sign = 1'b0;
        bus.a = 32'h0; bus.b = 32'h0; bus.flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("reset_state", {bus.busy, bus.done, bus.div_by_zero, bus.hi, bus.lo}, 64'h0);
        @(posedge clk); #1;

        run_op("mul_s_neg3x5",   2'b00, 1'b1, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        run_op("mul_u_max",      2'b00, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_op("div_s_neg7by2",  2'b01, 1'b1, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("div_u_7by2",     2'b01, 1'b0, 32'd7,         32'd2,        32'd1,         32'd3,         1'b0);
        run_op("div_s_ovf",      2'b01, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        32'h8000_0000, 1'b0);
        run_op("div_by_zero",    2'b01, 1'b0, 32'h0000_1234, 32'h0,        32'h0000_1234, 32'hFFFF_FFFF, 1'b1);
        run_op("div_s_by_zero",  2'b01, 1'b1, 32'hFFFF_FFF0, 32'h0,        32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1);
        run_op("mul_u_6x7",      2'b00, 1'b0, 32'd6,         32'd7,        32'h0,         32'd42,        1'b0);
        // Issued in the done cycle of the previous op: must be accepted.
        run_op("mul_s_b2b",      2'b00, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,        32'h1,         1'b0);
        @(posedge clk); #1;

        // Ignored second start, then flush mid-calculation.
        issue(2'b00, 1'b0, 32'd3, 32'd4);
        repeat (4) begin @(posedge clk); #1; end
        issue(2'b01, 1'b0, 32'd100, 32'd7);
        repeat (3) begin @(posedge clk); #1; end
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        chk("flush_busy", {63'h0, bus.busy}, 64'h0);
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done !== 1'b0) chk("flush_no_done", {63'h0, bus.done}, 64'h0);
        end
        chk("flush_hilo_kept", {bus.hi, bus.lo}, {32'h0, 32'h1});

        // Single-cycle moves while idle.
        issue(2'b10, 1'b0, 32'h0000_ABCD, 32'h0);
        chk("mthi_hi", {32'h0, bus.hi}, 64'h0000_ABCD);
        chk("mthi_busy", {63'h0, bus.busy}, 64'h0);
        issue(2'b11, 1'b0, 32'h1357_2468, 32'h0);
        chk("mtlo_lo", {32'h0, bus.lo}, 64'h1357_2468);
        bus.flush = 1'b1;
        issue(2'b11, 1'b0, 32'h5555_5555, 32'h0);
        bus.flush = 1'b0;
        chk("flush_drops_mtlo", {32'h0, bus.lo}, 64'h1357_2468);

        // Asynchronous reset in the middle of a calculation.
        issue(2'b00, 1'b0, 32'd5, 32'd6);
        repeat (9) begin @(posedge clk); #1; end
        chk("busy_before_rst", {63'h0, bus.busy}, 64'h1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_reset", {bus.busy, bus.done, bus.div_by_zero, bus.hi, bus.lo}, 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("mul_after_rst", 2'b00, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h1, 32'h0, 1'b0);
        @(posedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
